// File: rtl/array_readback_tx_if.sv
// rtl/array_readback_tx_if.sv - cell read port, control handshake and serial line of the snapshot sender
interface array_readback_tx_if #(
    parameter int X_BITS     = 4,
    parameter int Y_BITS     = 4,
    parameter int STATE_BITS = 1
);
    logic                  start;
    logic [STATE_BITS-1:0] state_in;
    logic [X_BITS-1:0]     adr_x_o;
    logic [Y_BITS-1:0]     adr_y_o;
    logic                  busy;
    logic                  done;
    logic                  tx;

    modport master (
        input  start, state_in,
        output adr_x_o, adr_y_o, busy, done, tx
    );

    modport slave (
        output start, state_in,
        input  adr_x_o, adr_y_o, busy, done, tx
    );
endinterface

// File: rtl/array_readback_tx.sv
// rtl/array_readback_tx.sv - scans the cell array and streams a framed snapshot out of an 8N1 UART
module array_readback_tx #(
    parameter int X_BITS       = 4,
    parameter int Y_BITS       = 4,
    parameter int X_MAX        = 15,
    parameter int Y_MAX        = 15,
    parameter int STATE_BITS   = 1,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    array_readback_tx_if.master  bus
);
    localparam int BYTES_PER_ROW = (X_MAX + 8) / 8;
    localparam int GRP_BITS      = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
    localparam int COL_BITS      = GRP_BITS + 3;
    localparam int CNT_BITS      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [COL_BITS-1:0] X_LAST   = COL_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0]   Y_LAST   = Y_BITS'(Y_MAX);
    localparam logic [GRP_BITS-1:0] GRP_LAST = GRP_BITS'(BYTES_PER_ROW - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, HDR, GATHER, SEND, TRL, FIN} state_t;
    typedef enum logic [1:0] {KIND_HDR, KIND_DATA, KIND_TRL} kind_t;

    state_t              state, state_next;
    kind_t               kind;
    logic [7:0]          shift;
    logic [CNT_BITS-1:0] clk_cnt;
    logic [3:0]          bit_idx;
    logic [2:0]          slot;
    logic                wait_read;
    logic [GRP_BITS-1:0] grp;
    logic [Y_BITS-1:0]   row;
    logic [X_BITS-1:0]   adr_x;
    logic [Y_BITS-1:0]   adr_y;
    logic [COL_BITS-1:0] col;
    logic                col_valid;
    logic                gather_done;
    logic                byte_end;
    logic                last_data;
    logic                tx_bit;

    assign col         = {grp, slot};
    assign col_valid   = (col <= X_LAST);
    assign gather_done = (slot == 3'd7) && (!col_valid || wait_read);
    assign byte_end    = (state == SEND) && (bit_idx == 4'd9) && (clk_cnt == CNT_LAST);
    assign last_data   = (row == Y_LAST) && (grp == GRP_LAST);

    assign bus.adr_x_o = adr_x;
    assign bus.adr_y_o = adr_y;
    assign bus.busy    = (state != IDLE) && (state != FIN);
    assign bus.done    = (state == FIN);
    assign bus.tx      = tx_bit;

    // State register; reset drops straight back to IDLE, aborting any byte in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: which byte just went out decides whether to gather, trail or finish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = HDR;
            HDR:     state_next = SEND;
            GATHER:  if (gather_done) state_next = SEND;
            SEND: begin
                if (byte_end) begin
                    case (kind)
                        KIND_HDR:  state_next = GATHER;
                        KIND_DATA: state_next = last_data ? TRL : GATHER;
                        default:   state_next = FIN;
                    endcase
                end
            end
            TRL:     state_next = SEND;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: cell scan with a one-cycle read settle per slot, byte shift register, bit timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind      <= KIND_HDR;
            shift     <= 8'h00;
            clk_cnt   <= '0;
            bit_idx   <= 4'd0;
            slot      <= 3'd0;
            wait_read <= 1'b0;
            grp       <= '0;
            row       <= '0;
            adr_x     <= '0;
            adr_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    grp       <= '0;
                    row       <= '0;
                    slot      <= 3'd0;
                    wait_read <= 1'b0;
                end
                HDR: begin
                    shift   <= 8'hA5;
                    kind    <= KIND_HDR;
                    clk_cnt <= '0;
                    bit_idx <= 4'd0;
                end
                GATHER: begin
                    kind    <= KIND_DATA;
                    clk_cnt <= '0;
                    bit_idx <= 4'd0;
                    if (!col_valid) begin
                        // padding column: no read, address stays on the last real column
                        shift[slot] <= 1'b0;
                        slot        <= slot + 3'd1;
                    end else if (!wait_read) begin
                        adr_x     <= X_BITS'(col);
                        adr_y     <= row;
                        wait_read <= 1'b1;
                    end else begin
                        shift[slot] <= |bus.state_in;
                        wait_read   <= 1'b0;
                        slot        <= slot + 3'd1;
                    end
                end
                SEND: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx <= 4'd0;
                            if (kind == KIND_DATA && !last_data) begin
                                if (grp == GRP_LAST) begin
                                    grp <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    grp <= grp + 1'b1;
                                end
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TRL: begin
                    shift   <= 8'h5A;
                    kind    <= KIND_TRL;
                    clk_cnt <= '0;
                    bit_idx <= 4'd0;
                end
                FIN: begin
                    adr_x <= '0;
                    adr_y <= '0;
                    grp   <= '0;
                    row   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Serial line: start bit, eight data bits LSB first, stop bit; idle high outside SEND.
    always_comb begin
        tx_bit = 1'b1;
        if (state == SEND) begin
            if (bit_idx == 4'd0)       tx_bit = 1'b0;
            else if (bit_idx <= 4'd8)  tx_bit = shift[3'(bit_idx - 4'd1)];
        end
    end
endmodule

// File: tb/tb_array_readback_tx.sv
// tb/tb_array_readback_tx.sv - directed frame captures checked against a byte-level snapshot model
module tb_array_readback_tx;
    localparam int CPB    = 4;
    localparam int NBYTES = 34;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit       cells_a [0:15][0:15];
    bit       cells_b [0:15][0:15];
    logic [7:0] rx_bytes [0:NBYTES-1];
    bit       adr_b_bad = 1'b0;
    bit       ab;

    array_readback_tx_if #(.X_BITS(4), .Y_BITS(4), .STATE_BITS(1)) if_a ();
    array_readback_tx_if #(.X_BITS(4), .Y_BITS(4), .STATE_BITS(1)) if_b ();

    array_readback_tx #(.X_BITS(4), .Y_BITS(4), .X_MAX(15), .Y_MAX(15),
                        .STATE_BITS(1), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.master));

    array_readback_tx #(.X_BITS(4), .Y_BITS(4), .X_MAX(9), .Y_MAX(15),
                        .STATE_BITS(1), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.master));

    assign if_a.state_in = cells_a[if_a.adr_y_o][if_a.adr_x_o];
    assign if_b.state_in = cells_b[if_b.adr_y_o][if_b.adr_x_o];

    always @(negedge clk) if (if_b.adr_x_o > 4'd9) adr_b_bad = 1'b1;

    function automatic logic tx_of(input int w);
        return (w == 0) ? if_a.tx : if_b.tx;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? if_a.busy : if_b.busy;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 0) ? if_a.done : if_b.done;
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 0) if_a.start = v;
        else        if_b.start = v;
    endtask

    // Snapshot model: header, rows of ceil((X_MAX+1)/8) bytes LSB = lowest x, trailer.
    function automatic logic [7:0] exp_byte(input int w, input int idx);
        int xmax, nb, d, y, k, x;
        logic [7:0] v;
        xmax = (w == 0) ? 15 : 9;
        nb   = (xmax + 8) / 8;
        if (idx == 0) return 8'hA5;
        if (idx == 1 + nb * 16) return 8'h5A;
        d = idx - 1;
        y = d / nb;
        k = d % nb;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            x = 8 * k + i;
            if (x <= xmax) v[i] = (w == 0) ? cells_a[y][x] : cells_b[y][x];
        end
        return v;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Start one frame and compare the serial line every cycle of every byte against the model.
    task automatic run_frame(input int w, input int mid_byte, input int abort_byte, output bit aborted);
        int wait_cnt, b, dcount;
        logic [7:0] eb, rb;
        logic expb;
        bit bad;
        aborted = 1'b0;
        @(negedge clk); set_start(w, 1'b1);
        @(negedge clk); set_start(w, 1'b0);
        check(busy_of(w) === 1'b1, "busy_rise", busy_of(w), 1);
        for (int idx = 0; idx < NBYTES; idx++) begin
            wait_cnt = 0;
            while (tx_of(w) !== 1'b0 && wait_cnt < 200) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (wait_cnt >= 200) begin
                check(1'b0, "start_bit_timeout", idx, -1);
                return;
            end
            eb  = exp_byte(w, idx);
            rb  = 8'h00;
            bad = 1'b0;
            for (int off = 0; off < 10 * CPB; off++) begin
                if (off > 0) @(negedge clk);
                b = off / CPB;
                expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
                if (tx_of(w) !== expb || busy_of(w) !== 1'b1 || done_of(w) !== 1'b0) bad = 1'b1;
                if (b >= 1 && b <= 8 && (off % CPB) == CPB / 2) rb[b-1] = tx_of(w);
                if (idx == mid_byte) begin
                    if (off == 20)      set_start(w, 1'b1);
                    else if (off == 21) set_start(w, 1'b0);
                end
                if (idx == abort_byte && off == 15) begin
                    reset = 1'b1;
                    #1;
                    check(tx_of(w) === 1'b1, "abort_tx", tx_of(w), 1);
                    check(busy_of(w) === 1'b0, "abort_busy", busy_of(w), 0);
                    aborted = 1'b1;
                    return;
                end
            end
            rx_bytes[idx] = rb;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL byte_%0d dut%0d: got %02h want %02h (or bad timing/busy/done)", idx, w, rb, eb);
            end
        end
        @(negedge clk);
        check(done_of(w) === 1'b1, "done_pulse", done_of(w), 1);
        check(busy_of(w) === 1'b0, "busy_fall", busy_of(w), 0);
        dcount = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_of(w) === 1'b1) dcount++;
        end
        check(dcount == 1, "done_once", dcount, 1);
    endtask

    initial begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                cells_a[y][x] = 1'b0;
                cells_b[y][x] = 1'b1;
            end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check(if_a.tx === 1'b1, "rst_tx", if_a.tx, 1);
        check(if_a.busy === 1'b0, "rst_busy", if_a.busy, 0);
        check(if_a.done === 1'b0, "rst_done", if_a.done, 0);
        check(if_a.adr_x_o === 4'd0, "rst_adr_x", if_a.adr_x_o, 0);
        check(if_a.adr_y_o === 4'd0, "rst_adr_y", if_a.adr_y_o, 0);
        check(if_b.tx === 1'b1, "rst_tx_b", if_b.tx, 1);
        reset = 1'b0;

        // all dead
        run_frame(0, -1, -1, ab);
        check(rx_bytes[0] === 8'hA5, "dead_hdr", rx_bytes[0], 8'hA5);
        check(rx_bytes[1] === 8'h00, "dead_data", rx_bytes[1], 8'h00);
        check(rx_bytes[33] === 8'h5A, "dead_trl", rx_bytes[33], 8'h5A);

        // glider
        cells_a[0][1] = 1'b1;
        cells_a[1][2] = 1'b1;
        cells_a[2][0] = 1'b1;
        cells_a[2][1] = 1'b1;
        cells_a[2][2] = 1'b1;
        check(exp_byte(0, 1) == 8'h02, "model_glider_r0", exp_byte(0, 1), 8'h02);
        check(exp_byte(0, 3) == 8'h04, "model_glider_r1", exp_byte(0, 3), 8'h04);
        check(exp_byte(0, 5) == 8'h07, "model_glider_r2", exp_byte(0, 5), 8'h07);
        run_frame(0, -1, -1, ab);
        check(rx_bytes[1] === 8'h02, "glider_r0", rx_bytes[1], 8'h02);
        check(rx_bytes[2] === 8'h00, "glider_r0b1", rx_bytes[2], 8'h00);
        check(rx_bytes[3] === 8'h04, "glider_r1", rx_bytes[3], 8'h04);
        check(rx_bytes[5] === 8'h07, "glider_r2", rx_bytes[5], 8'h07);
        check(rx_bytes[7] === 8'h00, "glider_r3", rx_bytes[7], 8'h00);

        // start while busy, mid-frame at byte 10
        run_frame(0, 10, -1, ab);

        // reset during data bits of byte 5, then a clean frame from the header
        run_frame(0, -1, 5, ab);
        check(ab == 1'b1, "abort_reached", ab, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check(if_a.busy === 1'b0, "post_abort_idle", if_a.busy, 0);
        run_frame(0, -1, -1, ab);
        check(rx_bytes[0] === 8'hA5, "post_abort_hdr", rx_bytes[0], 8'hA5);
        check(rx_bytes[5] === 8'h07, "post_abort_r2", rx_bytes[5], 8'h07);

        // narrow array: X_MAX=9, all alive
        check(exp_byte(1, 1) == 8'hFF, "model_b_lo", exp_byte(1, 1), 8'hFF);
        check(exp_byte(1, 2) == 8'h03, "model_b_hi", exp_byte(1, 2), 8'h03);
        run_frame(1, -1, -1, ab);
        check(rx_bytes[1] === 8'hFF, "b_row0_lo", rx_bytes[1], 8'hFF);
        check(rx_bytes[2] === 8'h03, "b_row0_hi", rx_bytes[2], 8'h03);
        check(rx_bytes[32] === 8'h03, "b_row15_hi", rx_bytes[32], 8'h03);
        check(adr_b_bad == 1'b0, "b_adr_x_bound", adr_b_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/array_readback_tx.md
Name: array_readback_tx

Overview:
Reader side of the pe_array cell interface. On a start pulse it scans every cell via adr_x_o/adr_y_o and packs the alive bits into bytes. It streams a framed snapshot of the current generation out of a UART transmitter (8N1), so a host can capture the board. It shares the read port with Display through an external mux; it holds a valid address only while busy is high.

Parameters:
X_BITS, 4, width of the x address
Y_BITS, 4, width of the y address
X_MAX, 15, last column index (columns 0..X_MAX)
Y_MAX, 15, last row index (rows 0..Y_MAX)
STATE_BITS, 1, width of the pe state; a cell is alive when the state is nonzero
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to send one snapshot
state_in  input  STATE_BITS  pe_array state_out for the currently driven address
adr_x_o  output  X_BITS  column being read
adr_y_o  output  Y_BITS  row being read
busy  output  1  high from accepted start until the last stop bit ends
done  output  1  one-cycle pulse after the final stop bit
tx  output  1  UART serial out, idle high

Behaviour:
- Reset values: tx=1, busy=0, done=0, adr_x_o=0, adr_y_o=0, FSM=IDLE. Reset mid-frame aborts at once. tx returns high without finishing the current byte.
- Frame format: header 0xA5, then rows y=0..Y_MAX, then trailer 0x5A.
  - Each row is B=ceil((X_MAX+1)/8) bytes.
  - Byte k of a row holds cells x=8k..8k+7, with bit i = cell 8k+i (LSB = lowest x).
  - Bit positions beyond X_MAX are 0.
- Frame length is 2 + B*(Y_MAX+1) bytes; the defaults give 34 bytes.
- Array read: state_in is combinational from the address, sampled the cycle after the address changes. The block registers the address, waits one cycle, then samples.
- FSM states:
  - IDLE: start → HDR; busy rises the cycle after start.
  - HDR: load 0xA5 into the shift register → SEND.
  - GATHER: for 8 bit slots, drive the address, wait one cycle, and sample alive into bit i. Slots past X_MAX write 0 without a read. Then → SEND.
  - SEND: UART shifts the byte out. On byte complete:
    - after the header or a non-final data byte → GATHER (next x group; at the row end, x=0 and y+1);
    - after the final data byte (y=Y_MAX, last group) → TRL;
    - after the trailer → FIN.
  - TRL: load 0x5A → SEND.
  - FIN: done=1 for one cycle, busy=0, addresses return to 0 → IDLE.
- UART: start bit 0, 8 data bits LSB first, stop bit 1, each held exactly CLKS_PER_BIT cycles.
  - A bit-counter wraps at CLKS_PER_BIT-1; the bit index runs 0..9.
  - There is no gap between bytes beyond GATHER time; tx stays 1 during GATHER.
- start while busy is ignored; start in the same cycle as FIN is also ignored.
- The snapshot is not atomic. Cells are read as they are scanned; if the array steps mid-frame, later bytes reflect the new generation.
- Address counters must not wrap past X_MAX/Y_MAX. adr_x_o is held at the last valid column during padding slots.

Test Plan:
- Reset, CLKS_PER_BIT=4, array all dead, pulse start → tx shows 34 frames: A5, 32×00, 5A. busy is high throughout. done pulses once, 34*40 + gather cycles later.
- Glider cells (1,0),(2,1),(0,2),(1,2),(2,2), pulse start → data bytes row0=02 00, row1=04 00, row2=07 00, rest 00.
- X_MAX=9 (B=2), all alive → each row bytes FF 03. Padding bits are 0, and adr_x_o never exceeds 9.
- Pulse start again at mid-frame byte 10 → ignored; frame identical to a single send, exactly one done.
- Assert reset during the data bits of byte 5 → tx=1 and busy=0 the same cycle (async). A new start afterwards yields a complete frame from the header.
- Bit timing check: every tx transition spaced at multiples of CLKS_PER_BIT. The stop bit is high for a full CLKS_PER_BIT before the next start bit.
